// File: rtl/data_mem_pkg.sv
// Shared constants and reset-value helper for the load/store data memory.
// The reset-value helper is used only when DATA_MEM_INIT_EN is defined.
package data_mem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 256;
    localparam int IDX_W  = $clog2(DEPTH);

    // Reset contents of word i when initialised reset is enabled: its own index.
    function automatic logic [DATA_W-1:0] init_word(input int unsigned i);
        return DATA_W'(i);
    endfunction

endpackage

// File: rtl/data_mem_ram.sv
// Word storage array: synchronous write, synchronous whole-array reset,
// asynchronous read. Build option DATA_MEM_INIT_EN selects the reset contents
// (word i <- i when defined, all zeros otherwise).
module data_mem_ram
    import data_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Reset rewrites every word and takes priority over a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
`ifdef DATA_MEM_INIT_EN
                r_mem[i] <= init_word(i);
`else
                r_mem[i] <= '0;
`endif
            end
        end else if (i_wr_en) begin
            r_mem[i_idx] <= i_wr_data;
        end
    end

    // No write-through: the read sees the array as it stands before the edge.
    assign o_rd_data = r_mem[i_idx];

endmodule

// File: rtl/data_memory.sv
// Word-addressed data memory for the load/store stage. The address is a word
// index; upper bits beyond the array depth are ignored so accesses wrap.
// Read data is combinational and forced to zero while read_en is low.
// Build option DATA_MEM_INIT_EN: reset loads word i with i instead of zero.
module data_memory
    import data_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic              wr_en,
    input  logic              read_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data_out
);

    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_unused_addr;

    assign w_idx         = address[IDX_W-1:0];
    assign w_unused_addr = ^address[ADDR_W-1:IDX_W];

    data_mem_ram u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (wr_en),
        .i_idx     (w_idx),
        .i_wr_data (wr_data),
        .o_rd_data (w_rd_data)
    );

    // Gate the read port so an idle load stage drives zeros onto the bus.
    always_comb begin
        data_out = '0;
        if (read_en) begin
            data_out = w_rd_data;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios followed by
// randomized traffic, compared against a plain array reference model.
module tb_data_memory;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int WORDS = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] address;
    logic          wr_en;
    logic          read_en;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] data_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] ref_mem [WORDS];
    bit            ref_valid = 1'b0;

    always #5 clk = ~clk;

    data_memory dut (
        .clk      (clk),
        .rst      (rst),
        .address  (address),
        .wr_en    (wr_en),
        .read_en  (read_en),
        .wr_data  (wr_data),
        .data_out (data_out)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] reset_value(input int i);
`ifdef DATA_MEM_INIT_EN
        return DW'(i);
`else
        return '0;
`endif
    endfunction

    function automatic logic [DW-1:0] expect_read(input logic re, input logic [AW-1:0] a);
        if (!re) return '0;
        return ref_mem[a % WORDS];
    endfunction

    // One clock cycle: drive, check before the edge, apply model, check after.
    task automatic cycle(input string tag, input logic r, input logic we, input logic re,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        rst     = r;
        wr_en   = we;
        read_en = re;
        address = a;
        wr_data = d;
        #1;
        if (ref_valid) chk({tag, "/pre"}, data_out, expect_read(re, a));
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < WORDS; i++) ref_mem[i] = reset_value(i);
            ref_valid = 1'b1;
        end else if (we) begin
            ref_mem[a % WORDS] = d;
        end
        #1;
        if (ref_valid) chk({tag, "/post"}, data_out, expect_read(re, a));
    endtask

    initial begin
        int rd_addrs [7] = '{32, 90, 127, 10, 17, 9, 255};
        rst = 1'b1; wr_en = 1'b0; read_en = 1'b0; address = '0; wr_data = '0;

        cycle("reset", 1, 0, 1, 0, 0);
        foreach (rd_addrs[k]) begin
            cycle($sformatf("rst_rd_%0d", rd_addrs[k]), 0, 0, 1, AW'(rd_addrs[k]), 0);
            chk($sformatf("rst_val_%0d", rd_addrs[k]), data_out, reset_value(rd_addrs[k]));
        end

        cycle("wr90", 0, 1, 0, 90, 66);
        cycle("wr51", 0, 1, 0, 51, 32'hFFFF_FF9E);
        cycle("rd51", 0, 0, 1, 51, 0);
        chk("rd51_abs", data_out, 32'hFFFF_FF9E);
        cycle("rd90", 0, 0, 1, 90, 0);
        chk("rd90_abs", data_out, 32'd66);
        cycle("rd51_off", 0, 0, 0, 51, 0);
        chk("rd_off_abs", data_out, 32'd0);

        cycle("wr256", 0, 1, 0, 256, 32'h1234_5678);
        cycle("rd0", 0, 0, 1, 0, 0);
        chk("wrap_abs", data_out, 32'h1234_5678);

        cycle("wr5", 0, 1, 0, 5, 7);
        rst = 0; wr_en = 1; read_en = 1; address = 5; wr_data = 9;
        #1 chk("rw5_before", data_out, 32'd7);
        cycle("rw5", 0, 1, 1, 5, 9);
        chk("rw5_after", data_out, 32'd9);

        cycle("rst_wr3", 1, 1, 1, 3, 32'hAA);
        chk("rst_prio_abs", data_out, reset_value(3));

        cycle("mid_wr51", 0, 1, 0, 51, 32'hDEAD_BEEF);
        cycle("mid_wr90", 0, 1, 1, 90, 32'hCAFE_F00D);
        cycle("mid_rst", 1, 0, 1, 51, 0);
        chk("mid_rst51", data_out, reset_value(51));
        cycle("mid_rd90", 0, 0, 1, 90, 0);
        chk("mid_rst90", data_out, reset_value(90));

        for (int n = 0; n < 400; n++) begin
            logic          r, we, re;
            logic [AW-1:0] a;
            r  = ($urandom_range(0, 49) == 0);
            we = $urandom_range(0, 1);
            re = ($urandom_range(0, 3) != 0);
            a  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            cycle($sformatf("rnd%0d_a%0h", n, a), r, we, re, a, DW'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
